// File: rtl/data_memory_port.sv
// Data-memory responder: word/half/byte loads and stores with a LATENCY-cycle wait and a Done pulse.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned word/half accesses instead of masking the low address bits.
module data_memory_port #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        R_Enable,
  input  logic        W_Enable,
  input  logic [1:0]  R_Width,
  input  logic [1:0]  W_Width,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        Done,
  output logic        Fault
);

  localparam int         IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] LatCount = 3'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [IdxW+1:0] addr_q;
  logic [31:0]     wdata_q;
  logic [1:0]      width_q;
  logic            write_q;
  logic            reqFault_q;
  logic [31:0]     readData_q, readData_d;
  logic            faultOut_q, faultOut_d;

  logic [31:0]     mem [DEPTH];

  logic            accept;
  logic            commit;
  logic            reqFault;
  logic            misaligned;
  logic [1:0]      reqWidth;
  logic [IdxW-1:0] wordIdx;
  logic [31:0]     memWord;
  logic [31:0]     loadData;
  logic [31:0]     laneData;
  logic [31:0]     mergedWord;
  logic [3:0]      laneMask;
  logic [7:0]      byteSel;
  logic [15:0]     halfSel;

  assign reqWidth = W_Enable ? W_Width : R_Width;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = ((reqWidth == 2'd0) && (Address[1:0] != 2'b00)) ||
                      ((reqWidth == 2'd1) && Address[0]);
`else
  assign misaligned = 1'b0;
`endif

  // Fault is decided at acceptance and carried with the request to its commit.
  assign reqFault = (Address[31:2] >= 30'(DEPTH)) | (reqWidth == 2'd3) |
                    (R_Enable & W_Enable) | misaligned;

  assign accept  = (state_q != WAIT) && (R_Enable || W_Enable);
  assign wordIdx = addr_q[IdxW+1:2];
  assign memWord = mem[wordIdx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = LatCount;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          commit  = 1'b1;
          cnt_d   = 3'd0;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_comb begin
    byteSel = memWord[8*addr_q[1:0] +: 8];
    halfSel = addr_q[1] ? memWord[31:16] : memWord[15:0];
    case (width_q)
      2'd0:    loadData = memWord;
      2'd1:    loadData = {{16{halfSel[15]}}, halfSel};
      default: loadData = {{24{byteSel[7]}}, byteSel};
    endcase
  end

  // Store lanes are replicated so the mask alone selects which bytes land.
  always_comb begin
    case (width_q)
      2'd0: begin
        laneMask = 4'hF;
        laneData = wdata_q;
      end
      2'd1: begin
        laneMask = addr_q[1] ? 4'b1100 : 4'b0011;
        laneData = {2{wdata_q[15:0]}};
      end
      default: begin
        laneMask = 4'b0001 << addr_q[1:0];
        laneData = {4{wdata_q[7:0]}};
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      mergedWord[8*i +: 8] = laneMask[i] ? laneData[8*i +: 8] : memWord[8*i +: 8];
    end
  end

  always_comb begin
    readData_d = readData_q;
    faultOut_d = 1'b0;
    if (commit) begin
      faultOut_d = reqFault_q;
      if (reqFault_q) begin
        readData_d = 32'd0;
      end else if (!write_q) begin
        readData_d = loadData;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      width_q    <= 2'd0;
      write_q    <= 1'b0;
      reqFault_q <= 1'b0;
      readData_q <= 32'd0;
      faultOut_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      readData_q <= readData_d;
      faultOut_q <= faultOut_d;
      if (accept) begin
        addr_q     <= Address[IdxW+1:0];
        wdata_q    <= WriteData;
        width_q    <= reqWidth;
        write_q    <= W_Enable;
        reqFault_q <= reqFault;
      end
    end
  end

  // Array is never cleared; a reset landing on the commit edge drops the store.
  always_ff @(posedge Clk) begin
    if (!Reset && commit && write_q && !reqFault_q) begin
      mem[wordIdx] <= mergedWord;
    end
  end

  assign Busy     = (state_q == WAIT);
  assign Done     = (state_q == DONE);
  assign Fault    = faultOut_q;
  assign ReadData = readData_q;

endmodule
